// File: rtl/vga_frame_sched.sv
// Frame-synchronous scheduler: sequences picture mode, horizontal scroll and
// hold configuration so that every vga_pic-facing output changes only at a vsync fall.
module vga_frame_sched #(
    parameter int NUM_MODES   = 4,
    parameter int MODE_W      = 2,
    parameter int HOLD_FRAMES = 120,
    parameter int SCROLL_STEP = 2,
    parameter int SCROLL_WRAP = 640
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              vsync,
    input  logic              pause,
    input  logic              next_req,
    input  logic              cfg_valid,
    input  logic [7:0]        cfg_hold,
    output logic              cfg_ready,
    output logic              frame_start,
    output logic [MODE_W-1:0] mode,
    output logic [9:0]        scroll_x,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [10:0]       STEP_C      = 11'(SCROLL_STEP);
    localparam logic [10:0]       WRAP_C      = 11'(SCROLL_WRAP);
    localparam logic [7:0]        HOLD_RST_C  = 8'(HOLD_FRAMES);
    localparam logic [MODE_W-1:0] LAST_MODE_C = MODE_W'(NUM_MODES - 1);

    // Scroll advance: 11-bit sum with a single conditional subtract of the modulus.
    function automatic logic [9:0] scroll_add(input logic [9:0] cur);
        logic [10:0] sum;
        sum = {1'b0, cur} + STEP_C;
        if (sum >= WRAP_C) begin
            sum = sum - WRAP_C;
        end else begin
            sum = sum;
        end
        return 10'(sum);
    endfunction

    function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] cur);
        if (cur == LAST_MODE_C) begin
            return {MODE_W{1'b0}};
        end else begin
            return cur + MODE_W'(1);
        end
    endfunction

    state_t              state_r, state_next_s;
    logic                vsync_d_r;
    logic                frame_start_r, frame_start_next_s;
    logic [MODE_W-1:0]   mode_r, mode_next_s;
    logic [9:0]          scroll_r, scroll_next_s;
    logic [15:0]         frame_cnt_r, frame_cnt_next_s;
    logic                cfg_ready_r, cfg_ready_next_s;
    logic [7:0]          hold_pend_r, hold_pend_next_s;
    logic [7:0]          hold_reg_r, hold_reg_next_s;
    logic [7:0]          hold_cnt_r, hold_cnt_next_s;
    logic                skip_pend_r, skip_pend_next_s;
    logic                edge_s;
    logic                auto_s;
    logic                advance_s;

    assign edge_s = vsync_d_r & ~vsync;
    assign auto_s = (hold_reg_r != 8'd0) && (hold_cnt_r == (hold_reg_r - 8'd1));

    // FSM state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= ST_WAIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and boundary update; a cfg already pending (ready low) is applied
    // at the boundary, while one offered in the edge cycle waits for the next frame.
    always_comb begin
        state_next_s       = state_r;
        frame_start_next_s = 1'b0;
        mode_next_s        = mode_r;
        scroll_next_s      = scroll_r;
        frame_cnt_next_s   = frame_cnt_r;
        cfg_ready_next_s   = cfg_ready_r;
        hold_pend_next_s   = hold_pend_r;
        hold_reg_next_s    = hold_reg_r;
        hold_cnt_next_s    = hold_cnt_r;
        skip_pend_next_s   = skip_pend_r;
        advance_s          = 1'b0;

        if (edge_s) begin
            frame_start_next_s = 1'b1;
            frame_cnt_next_s   = frame_cnt_r + 16'd1;
            skip_pend_next_s   = next_req;
            state_next_s       = pause ? ST_PAUSE : ST_RUN;

            case (state_r)
                ST_WAIT: begin
                    advance_s = 1'b0;
                end
                ST_RUN: begin
                    scroll_next_s = scroll_add(scroll_r);
                    advance_s     = skip_pend_r | auto_s;
                    if (advance_s) begin
                        hold_cnt_next_s = 8'd0;
                    end else begin
                        hold_cnt_next_s = hold_cnt_r + 8'd1;
                    end
                end
                ST_PAUSE: begin
                    advance_s = skip_pend_r;
                    if (advance_s) begin
                        hold_cnt_next_s = 8'd0;
                    end else begin
                        hold_cnt_next_s = hold_cnt_r;
                    end
                end
                default: begin
                    advance_s    = 1'b0;
                    state_next_s = ST_WAIT;
                end
            endcase

            if (advance_s) begin
                mode_next_s = mode_inc(mode_r);
            end else begin
                mode_next_s = mode_r;
            end

            if (!cfg_ready_r) begin
                hold_reg_next_s  = hold_pend_r;
                hold_cnt_next_s  = 8'd0;
                cfg_ready_next_s = 1'b1;
            end else if (cfg_valid) begin
                hold_pend_next_s = cfg_hold;
                cfg_ready_next_s = 1'b0;
            end else begin
                cfg_ready_next_s = 1'b1;
            end
        end else begin
            skip_pend_next_s = skip_pend_r | next_req;
            if (cfg_valid && cfg_ready_r) begin
                hold_pend_next_s = cfg_hold;
                cfg_ready_next_s = 1'b0;
            end else begin
                cfg_ready_next_s = cfg_ready_r;
            end
        end
    end

    // Datapath registers; vsync_d resets low so release during sync gives no edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vsync_d_r     <= 1'b0;
            frame_start_r <= 1'b0;
            mode_r        <= {MODE_W{1'b0}};
            scroll_r      <= 10'd0;
            frame_cnt_r   <= 16'd0;
            cfg_ready_r   <= 1'b1;
            hold_pend_r   <= 8'd0;
            hold_reg_r    <= HOLD_RST_C;
            hold_cnt_r    <= 8'd0;
            skip_pend_r   <= 1'b0;
        end else begin
            vsync_d_r     <= vsync;
            frame_start_r <= frame_start_next_s;
            mode_r        <= mode_next_s;
            scroll_r      <= scroll_next_s;
            frame_cnt_r   <= frame_cnt_next_s;
            cfg_ready_r   <= cfg_ready_next_s;
            hold_pend_r   <= hold_pend_next_s;
            hold_reg_r    <= hold_reg_next_s;
            hold_cnt_r    <= hold_cnt_next_s;
            skip_pend_r   <= skip_pend_next_s;
        end
    end

    assign frame_start = frame_start_r;
    assign mode        = mode_r;
    assign scroll_x    = scroll_r;
    assign frame_cnt   = frame_cnt_r;
    assign cfg_ready   = cfg_ready_r;

endmodule
